// File: rtl/hex_scan_mux_pkg.sv
// Shared constants for the multiplexed hex display scanner.
// Anode and decimal-point drives are active-low.
package hex_scan_mux_pkg;

  localparam int   NIB_W     = 4;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_OFF    = 1'b1;

endpackage

// File: rtl/hex_scan_mux_scan_tick_gen.sv
// Slot timer for the display scanner.
// Flags the first cycle, last cycle and dead-time cycles of a digit slot.
module scan_tick_gen #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start_o,
  output logic slot_end_o,
  output logic dead_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign slot_start_o = (cnt_q == '0);
  assign slot_end_o   = (cnt_q == CNT_LAST);
  assign dead_o       = (cnt_q < CNT_DEAD);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (slot_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scan_mux.sv
// Time-multiplexed hex digit feeder for a shared seven-segment decoder.
// Frame-coherent loads, anode dead time, leading-zero blanking, DP drive.
module hex_scan_mux
  import hex_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        blank_lz,
  output logic [NIB_W-1:0]            hex_out,
  output logic [NUM_DIGITS-1:0]       digit_an,
  output logic                        dp_n,
  output logic                        frame_start
);

  localparam int VW = NIB_W * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{ANODE_OFF}};

  logic slot_start;
  logic slot_end;
  logic dead;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYC    (DEAD_CYC)
  ) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_start_o (slot_start),
    .slot_end_o   (slot_end),
    .dead_o       (dead)
  );

  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [VW-1:0]         pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_q, pend_d;
  logic                  blk_q;
  logic [NIB_W-1:0]      hex_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  dpn_q;
  logic                  fs_q;

  logic                  xfer;
  logic [NIB_W-1:0]      nib_d;
  logic                  dp_cur;
  logic                  blank_d;
  logic [NUM_DIGITS-1:0] hi_zero;
  logic [NUM_DIGITS-1:0] an_lit;
  logic                  zrun;

  assign xfer = slot_start && (idx_q == '0);

  // A load coinciding with the transfer edge skips pending entirely.
  always_comb begin
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    if (xfer) begin
      pend_d = 1'b0;
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_in;
      end else if (pend_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    hi_zero = '0;
    zrun    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun = zrun && (act_val_d[i*NIB_W +: NIB_W] == '0)
                  && !act_dp_d[i];
      hi_zero[i] = zrun;
    end
  end

  always_comb begin
    an_lit = AN_ALL_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(idx_q)) an_lit[i] = ~ANODE_OFF;
    end
  end

  assign nib_d   = act_val_d[int'(idx_q)*NIB_W +: NIB_W];
  assign dp_cur  = act_dp_d[idx_q];
  assign blank_d = blank_lz && (idx_q != '0) && hi_zero[idx_q];

  always_comb begin
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      blk_q      <= 1'b0;
      hex_q      <= '0;
      an_q       <= AN_ALL_OFF;
      dpn_q      <= DP_OFF;
      fs_q       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      if (slot_start) begin
        hex_q <= nib_d;
        dpn_q <= blank_d ? DP_OFF : ~dp_cur;
        blk_q <= blank_d;
        fs_q  <= (idx_q == '0);
        an_q  <= AN_ALL_OFF;
      end else begin
        fs_q <= 1'b0;
        an_q <= (dead || blk_q) ? AN_ALL_OFF : an_lit;
      end
    end
  end

  assign hex_out     = hex_q;
  assign digit_an    = an_q;
  assign dp_n        = dpn_q;
  assign frame_start = fs_q;

endmodule
